// File: rtl/shift_frame_pkg.sv
// rtl/shift_frame_pkg.sv - shared types and frame-length helper; SHIFT_FRAME_RECEIVER_PARITY_EN adds a parity bit per frame
package shift_frame_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    function automatic int frame_len(input int width);
`ifdef SHIFT_FRAME_RECEIVER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/shift_frame_bit_counter.sv
// rtl/shift_frame_bit_counter.sv - per-frame bit counter with load-to-1 and last-bit flag
module shift_frame_bit_counter #(
    parameter int LEN = 4,
    parameter int CW  = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  logic inc,
    output logic at_last
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // High while the next counted bit brings the count to LEN, i.e. ends the frame.
    assign at_last = (count == CW'(LEN - 1));

endmodule

// File: rtl/shift_frame_receiver.sv
// rtl/shift_frame_receiver.sv - serial-in/parallel-out frame receiver with double-buffered output
// Optional even-parity bit per frame: define SHIFT_FRAME_RECEIVER_PARITY_EN.
module shift_frame_receiver
    import shift_frame_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_first,
    input  logic             dir,
    output logic [WIDTH-1:0] Parallel_Out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun_err,
    output logic             framing_err,
    output logic             parity_err,
    input  logic             err_clr
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_I     = (FRAME_LEN > (2 ** CNT_W) - 1) ? CNT_W + 1 : CNT_W;

    state_t           state, state_nxt;
    logic             dir_q;
    logic [WIDTH-1:0] sr, sr_shift, final_word;
    logic             start, stray, data_bit, at_last, complete;
    logic             shift_en, word_ok, load_word, overrun;

    assign start    = sin_valid && sin_first;
    assign stray    = sin_valid && !sin_first && (state == IDLE);
    assign data_bit = sin_valid && !sin_first && (state == RECV);
    assign complete = data_bit && at_last;
    assign sr_shift = (dir_q == DIR_MSB_FIRST) ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};

`ifdef SHIFT_FRAME_RECEIVER_PARITY_EN
    logic par;

    // The closing bit is the parity bit; it is checked but never shifted in.
    assign shift_en   = data_bit && !at_last;
    assign final_word = sr;
    assign word_ok    = ((par ^ sin) == 1'b0);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            par        <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (start) begin
                par <= sin;
            end else if (data_bit) begin
                par <= par ^ sin;
            end
            parity_err <= (complete && !word_ok) || (parity_err && !err_clr);
        end
    end
`else
    assign shift_en   = data_bit;
    assign final_word = sr_shift;
    assign word_ok    = 1'b1;
    assign parity_err = 1'b0;
`endif

    assign load_word = complete && word_ok && (!out_valid || out_ready);
    assign overrun   = complete && word_ok && out_valid && !out_ready;

    shift_frame_bit_counter #(
        .LEN(FRAME_LEN),
        .CW (CNT_I)
    ) u_bit_counter (
        .clk    (clk),
        .clear  (clear),
        .load   (start),
        .inc    (data_bit),
        .at_last(at_last)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RECV;
        end else if (complete) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (state == RECV);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sr           <= '0;
            dir_q        <= DIR_MSB_FIRST;
            Parallel_Out <= '0;
            out_valid    <= 1'b0;
            framing_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            if (start) begin
                dir_q <= dir;
                sr    <= (dir == DIR_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, sin}
                                                : {sin, {(WIDTH-1){1'b0}}};
            end else if (shift_en) begin
                sr <= sr_shift;
            end
            if (load_word) begin
                Parallel_Out <= final_word;
                out_valid    <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Error events take priority over err_clr on the same edge.
            framing_err <= (start && (state == RECV)) || stray || (framing_err && !err_clr);
            overrun_err <= overrun || (overrun_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_shift_frame_receiver.sv
// tb/tb_shift_frame_receiver.sv - directed self-checking bench for shift_frame_receiver (WIDTH=4)
module tb_shift_frame_receiver;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_first = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] Parallel_Out;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       overrun_err;
    logic       framing_err;
    logic       parity_err;
    logic       err_clr = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    shift_frame_receiver #(.WIDTH(4)) dut (
        .clk         (clk),
        .clear       (clear),
        .sin         (sin),
        .sin_valid   (sin_valid),
        .sin_first   (sin_first),
        .dir         (dir),
        .Parallel_Out(Parallel_Out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun_err (overrun_err),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic first, input logic d);
        sin = b; sin_valid = 1'b1; sin_first = first; dir = d;
        tick();
        sin_valid = 1'b0; sin_first = 1'b0;
    endtask

    // Sends seq[3] first; with ready_last, out_ready rises for the frame's closing bit.
    task automatic send_seq(input logic [3:0] seq, input logic d, input logic ready_last);
        logic [3:0] s;
        s = seq;
        for (int i = 3; i >= 0; i--) begin
`ifndef SHIFT_FRAME_RECEIVER_PARITY_EN
            if (i == 0 && ready_last) out_ready = 1'b1;
`endif
            send_bit(s[i], (i == 3), d);
        end
`ifdef SHIFT_FRAME_RECEIVER_PARITY_EN
        if (ready_last) out_ready = 1'b1;
        send_bit(^s, 1'b0, d);
`endif
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (Parallel_Out !== 4'h0) begin tests_failed++; $display("FAIL reset_po got=%h exp=0", Parallel_Out); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if ({overrun_err, framing_err, parity_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_errs got=%b exp=000", {overrun_err, framing_err, parity_err}); end
        clear = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        out_ready = 1'b1;
        send_seq(4'b1011, 1'b0, 1'b0);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL msb_valid got=%b exp=1", out_valid); end
        tests_run++; if (Parallel_Out !== 4'b1011) begin tests_failed++; $display("FAIL msb_po got=%b exp=1011", Parallel_Out); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL msb_busy got=%b exp=0", busy); end
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL msb_valid_one_cycle got=%b exp=0", out_valid); end
    endtask

    task automatic test_lsb_gaps();
        logic [3:0] s;
        s = 4'b1011;
        out_ready = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            send_bit(s[i], (i == 3), 1'b1);
            if (i > 0) begin
                repeat (3) tick();
                tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL lsb_busy bit=%0d got=%b exp=1", i, busy); end
                tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL lsb_early_valid bit=%0d got=%b exp=0", i, out_valid); end
            end
        end
`ifdef SHIFT_FRAME_RECEIVER_PARITY_EN
        send_bit(1'b1, 1'b0, 1'b1);
`endif
        tests_run++; if (Parallel_Out !== 4'b1101) begin tests_failed++; $display("FAIL lsb_po got=%b exp=1101", Parallel_Out); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL lsb_valid got=%b exp=1", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lsb_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_overrun();
        drain();
        out_ready = 1'b0;
        send_seq(4'hA, 1'b0, 1'b0);
        tests_run++; if (Parallel_Out !== 4'hA) begin tests_failed++; $display("FAIL ovr_first got=%h exp=a", Parallel_Out); end
        send_seq(4'h5, 1'b0, 1'b0);
        tests_run++; if (Parallel_Out !== 4'hA) begin tests_failed++; $display("FAIL ovr_hold got=%h exp=a", Parallel_Out); end
        tests_run++; if (overrun_err !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag got=%b exp=1", overrun_err); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++; if (overrun_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_clr got=%b exp=0", overrun_err); end
        send_seq(4'h3, 1'b0, 1'b1);
        tests_run++; if (Parallel_Out !== 4'h3) begin tests_failed++; $display("FAIL ovr_reload got=%h exp=3", Parallel_Out); end
        tests_run++; if (overrun_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_no_new got=%b exp=0", overrun_err); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_valid_stays got=%b exp=1", out_valid); end
    endtask

    task automatic test_resync();
        drain();
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_seq(4'b0110, 1'b0, 1'b0);
        tests_run++; if (Parallel_Out !== 4'b0110) begin tests_failed++; $display("FAIL resync_po got=%b exp=0110", Parallel_Out); end
        tests_run++; if (framing_err !== 1'b1) begin tests_failed++; $display("FAIL resync_flag got=%b exp=1", framing_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++; if (framing_err !== 1'b0) begin tests_failed++; $display("FAIL framing_clr got=%b exp=0", framing_err); end
        err_clr = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        tests_run++; if (framing_err !== 1'b1) begin tests_failed++; $display("FAIL set_wins got=%b exp=1", framing_err); end
        tests_run++; if (Parallel_Out !== 4'b0110) begin tests_failed++; $display("FAIL stray_po got=%b exp=0110", Parallel_Out); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_clear_midframe();
        out_ready = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        #1;
        tests_run++; if (Parallel_Out !== 4'h0) begin tests_failed++; $display("FAIL clr_po got=%h exp=0", Parallel_Out); end
        tests_run++; if ({busy, out_valid} !== 2'b00) begin tests_failed++; $display("FAIL clr_busy_valid got=%b exp=00", {busy, out_valid}); end
        #2;
        clear = 1'b0;
        tick();
        out_ready = 1'b1;
        send_seq(4'b1001, 1'b0, 1'b0);
        tests_run++; if (Parallel_Out !== 4'b1001) begin tests_failed++; $display("FAIL clr_after_po got=%b exp=1001", Parallel_Out); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL clr_after_valid got=%b exp=1", out_valid); end
    endtask

    task automatic test_back_to_back();
        drain();
        send_seq(4'b1100, 1'b0, 1'b0);
        tests_run++; if (Parallel_Out !== 4'b1100) begin tests_failed++; $display("FAIL b2b_first got=%b exp=1100", Parallel_Out); end
        send_seq(4'b0011, 1'b1, 1'b0);
        tests_run++; if (Parallel_Out !== 4'b1100) begin tests_failed++; $display("FAIL b2b_second got=%b exp=1100", Parallel_Out); end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        tests_run++; if ({overrun_err, framing_err} !== 2'b00) begin tests_failed++; $display("FAIL b2b_errs got=%b exp=00", {overrun_err, framing_err}); end
    endtask

`ifdef SHIFT_FRAME_RECEIVER_PARITY_EN
    task automatic test_parity();
        logic [3:0] s;
        s = 4'b1011;
        drain();
        for (int i = 3; i >= 0; i--) send_bit(s[i], (i == 3), 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        tests_run++; if ({out_valid, Parallel_Out} !== 5'b1_1011) begin tests_failed++; $display("FAIL par_ok got=%b exp=11011", {out_valid, Parallel_Out}); end
        tests_run++; if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL par_ok_flag got=%b exp=0", parity_err); end
        drain();
        for (int i = 3; i >= 0; i--) send_bit(s[i], (i == 3), 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL par_bad_valid got=%b exp=0", out_valid); end
        tests_run++; if (parity_err !== 1'b1) begin tests_failed++; $display("FAIL par_bad_flag got=%b exp=1", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_overrun();
        test_resync();
        test_clear_midframe();
        test_back_to_back();
`ifdef SHIFT_FRAME_RECEIVER_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_frame_receiver.md
Name: shift_frame_receiver

Overview:
Serial-in/parallel-out frame receiver. It is the receiving end of the universal shift register when that register is used as a serial transmitter.
- Collects WIDTH bits from a bit-valid serial stream, MSB-first or LSB-first, selected per frame.
- Presents each completed word on a double-buffered parallel output with a valid/ready handshake.
- Sits between a serial link and the parallel datapath.

Parameters:
WIDTH, 4, data bits per frame (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  clock, all state updates on posedge
clear  input  1  asynchronous, active-high reset
sin  input  1  serial data bit
sin_valid  input  1  sin carries a bit this cycle
sin_first  input  1  with sin_valid: this bit is bit 0 of a new frame
dir  input  1  sampled with the first bit; 0 = MSB-first (shift left), 1 = LSB-first (shift right)
Parallel_Out  output  WIDTH  received word (holding register)
out_valid  output  1  Parallel_Out holds an unconsumed word
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  frame reception in progress (state RECV)
overrun_err  output  1  sticky: completed word dropped because the holding register was full
framing_err  output  1  sticky: stray bit in IDLE, or sin_first inside a frame
parity_err  output  1  sticky: parity mismatch (PARITY_EN only, else constant 0)
err_clr  input  1  synchronous clear of all sticky error flags

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE; shift register, counter and Parallel_Out = 0; out_valid, busy and all error flags = 0. Reset mid-frame discards the partial word.
- States:
  - IDLE, busy=0.
    - sin_valid && sin_first: latch dir, load first bit, count=1, go to RECV.
    - sin_valid && !sin_first: bit ignored, framing_err<=1.
  - RECV, busy=1. Each sin_valid shifts one bit:
    - dir=0: sr<={sr[WIDTH-2:0],sin}.
    - dir=1: sr<={sin,sr[WIDTH-1:1]}.
    - count increments.
    - On the bit that makes count==WIDTH: word complete, return to IDLE.
- sin_valid=0 stalls without timeout; gaps between bits are allowed.
- sin_first in RECV: resync. The current partial word is discarded, the new frame starts with this bit (count=1, dir re-latched), and framing_err<=1.
- Completion and handshake:
  - On completion the word is moved to Parallel_Out. out_valid rises the cycle after the last bit (latency 1 clk from the last bit).
  - Handshake on the same edge (out_valid && out_ready): out_valid falls next cycle unless a new word completes on that edge.
  - Completion while out_valid=1 and out_ready=0: new word dropped, Parallel_Out unchanged, overrun_err<=1.
  - Completion while out_valid=1 and out_ready=1: no overrun, new word loaded, out_valid stays 1.
- Back-to-back frames: a frame may start on the cycle right after the last bit of the previous frame; no idle cycle is required.
- err_clr: clears the sticky error flags on the next edge. If an error event occurs on the same edge as err_clr, the flag is set (set wins).
- Parallel_Out changes only on a successful load.

Optional Feature:
Macro: SHIFT_FRAME_RECEIVER_PARITY_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the WIDTH data bits; completion happens at count==WIDTH+1.
  - Parity is the XOR of the data bits plus the parity bit and must equal 0.
  - On mismatch the word is dropped (no load, no overrun check) and parity_err<=1.
  - The parity bit is never shifted into the word.
- Undefined: frames are WIDTH bits and parity_err is tied to 0.

Decomposition:
- Package shift_frame_pkg:
  - State enum {IDLE, RECV}.
  - Constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
  - Helper function for frame length (WIDTH or WIDTH+1).
- One sub-module is natural: shift_frame_bit_counter, which provides load-to-1, increment on valid, and a terminal flag at the frame length. Everything else stays in the top module.

Test Plan:
- WIDTH=4, dir=0, bits 1,0,1,1 (first flagged), out_ready=1 -> Parallel_Out=4'b1011, out_valid high exactly one cycle, 1 clk after the last bit.
- dir=1, bits 1,0,1,1, with sin_valid gaps of 3 cycles between bits -> Parallel_Out=4'b1101; busy high from first to last bit.
- out_ready=0; frames 4'hA then 4'h5 -> Parallel_Out stays 4'hA and overrun_err=1. Then out_ready=1 on the completing edge of a third frame 4'h3 -> no new error, Parallel_Out=4'h3.
- Two bits of a frame, then sin_first with bits 0,1,1,0 (dir=0) -> Parallel_Out=4'b0110 and framing_err=1. Pulse err_clr -> framing_err=0.
- Assert clear mid-frame after 2 bits -> all outputs 0 immediately. A subsequent full frame 4'b1001 is received correctly.
- PARITY_EN: data 1,0,1,1 with parity 1 -> accepted. Same data with parity 0 -> no out_valid, parity_err=1.
